// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_ctrl_pkg
// Description : Shared types and constants for the pipeline controller:
//               FSM state encoding, default counter width and memory
//               timeout, and the bundle of five pipeline control strobes
//               with its canonical values.
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

  localparam int c_cnt_w_default       = 16;
  localparam int c_mem_timeout_default = 255;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_MEM_WAIT   = 2'd1,
    ST_LOAD_STALL = 2'd2
  } state_e;

  // Field order matches the bit order used when the strobes are viewed as a
  // 5-bit word: {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, EX_MEM_Hold}.
  typedef struct packed {
    logic pc_write;
    logic if_id_write;
    logic if_id_flush;
    logic id_ex_bubble;
    logic ex_mem_hold;
  } ctrl_t;

  localparam ctrl_t c_ctrl_pass   = 5'b11000; // normal flow
  localparam ctrl_t c_ctrl_freeze = 5'b00001; // data memory not ready
  localparam ctrl_t c_ctrl_flush  = 5'b11110; // taken branch squashes IF/ID and ID/EX
  localparam ctrl_t c_ctrl_stall  = 5'b00010; // load-use: hold front end, bubble ID/EX

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Saturating up-counter with synchronous clear. The clear wins
//               over an increment in the same cycle; the count sticks at the
//               all-ones value instead of wrapping.
// Ports       : clk_i   - clock
//               rst_i   - asynchronous active-high reset
//               inc_i   - increment request
//               clr_i   - synchronous clear
//               count_o - current count
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (clr_i) begin
      count_q <= '0;
    end else if (inc_i && (count_q != {WIDTH{1'b1}})) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count_o = count_q;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_ctrl
// Description : Pipeline stall/flush controller. Decodes memory-busy, taken
//               branch and load-use hazard events (in that priority) into
//               pipeline register enables, tracks a three-state FSM, keeps
//               saturating stall/flush performance counters and two sticky
//               error flags (hazard repeated during a load stall, memory wait
//               exceeding MEM_TIMEOUT cycles).
// Ports       : clk             - clock, rising edge
//               reset           - asynchronous active-high reset
//               hazard_detected - load-use hazard
//               branch_taken    - taken branch/jump resolved this cycle
//               dmem_busy       - data memory not ready
//               clear_counters  - synchronous clear of both perf counters
//               PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble,
//               EX_MEM_Hold     - combinational pipeline strobes
//               state           - current FSM state (RUN/MEM_WAIT/LOAD_STALL)
//               stall_count     - cycles with PCWrite low (saturating)
//               flush_count     - branch flushes (saturating)
//               protocol_err    - sticky: hazard seen while in LOAD_STALL
//               timeout_err     - sticky: MEM_WAIT reached MEM_TIMEOUT cycles
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = c_mem_timeout_default,
  parameter int CNT_W       = c_cnt_w_default
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             hazard_detected,
  input  logic             branch_taken,
  input  logic             dmem_busy,
  input  logic             clear_counters,
  output logic             PCWrite,
  output logic             IF_ID_Write,
  output logic             IF_ID_Flush,
  output logic             ID_EX_Bubble,
  output logic             EX_MEM_Hold,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count,
  output logic             protocol_err,
  output logic             timeout_err
);

  localparam int c_wait_w = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [c_wait_w-1:0] c_wait_max = c_wait_w'(MEM_TIMEOUT);

  state_e              state_q, state_d;
  logic [c_wait_w-1:0] wait_q, wait_d;
  logic                perr_q, perr_d;
  logic                terr_q, terr_d;

  ctrl_t               w_ctrl;
  logic                w_flush_inc;
  logic                w_stall_inc;

  // --------------------------------------------------------------------------
  // Event decode. MEM_WAIT with memory released and LOAD_STALL both fall
  // through to the same branch/hazard/pass evaluation as RUN; the only
  // state-specific differences are the wait counter and the repeated-hazard
  // case in LOAD_STALL.
  // --------------------------------------------------------------------------
  always_comb begin
    w_ctrl      = c_ctrl_pass;
    w_flush_inc = 1'b0;
    state_d     = ST_RUN;
    wait_d      = wait_q;
    perr_d      = perr_q;
    terr_d      = terr_q;

    if (dmem_busy) begin
      w_ctrl  = c_ctrl_freeze;
      state_d = ST_MEM_WAIT;
      if (state_q == ST_MEM_WAIT) begin
        if (wait_q != c_wait_max) begin
          wait_d = wait_q + c_wait_w'(1);
        end
        if (wait_d == c_wait_max) begin
          terr_d = 1'b1;
        end
      end else begin
        // Entering MEM_WAIT: the wait count starts fresh.
        wait_d = '0;
      end
    end else if (branch_taken) begin
      // Any simultaneous hazard is squashed by the flush itself.
      w_ctrl      = c_ctrl_flush;
      w_flush_inc = 1'b1;
    end else if (hazard_detected) begin
      if (state_q == ST_LOAD_STALL) begin
        // The stall already resolved the load-use; a second hazard is a
        // fault upstream. Let the pipeline advance and flag it.
        perr_d = 1'b1;
      end else begin
        w_ctrl  = c_ctrl_stall;
        state_d = ST_LOAD_STALL;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
      wait_q  <= '0;
      perr_q  <= 1'b0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      perr_q  <= perr_d;
      terr_q  <= terr_d;
    end
  end

  // Strobes are forced low for the whole reset window, whatever the inputs.
  assign PCWrite      = w_ctrl.pc_write     & ~reset;
  assign IF_ID_Write  = w_ctrl.if_id_write  & ~reset;
  assign IF_ID_Flush  = w_ctrl.if_id_flush  & ~reset;
  assign ID_EX_Bubble = w_ctrl.id_ex_bubble & ~reset;
  assign EX_MEM_Hold  = w_ctrl.ex_mem_hold  & ~reset;

  assign w_stall_inc  = ~w_ctrl.pc_write;

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_stall_cnt (
    .clk_i   (clk),
    .rst_i   (reset),
    .inc_i   (w_stall_inc),
    .clr_i   (clear_counters),
    .count_o (stall_count)
  );

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_flush_cnt (
    .clk_i   (clk),
    .rst_i   (reset),
    .inc_i   (w_flush_inc),
    .clr_i   (clear_counters),
    .count_o (flush_count)
  );

  assign state        = state_q;
  assign protocol_err = perr_q;
  assign timeout_err  = terr_q;

endmodule : pipeline_ctrl
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_ctrl
// Description : Directed scoreboard bench for pipeline_ctrl with CNT_W=2 and
//               MEM_TIMEOUT=4. Each stimulus cycle queues the hand-computed
//               outputs expected during that cycle; a negedge monitor pops
//               and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

  localparam int TB_CNT_W       = 2;
  localparam int TB_MEM_TIMEOUT = 4;

  // Strobe words: {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, EX_MEM_Hold}
  localparam logic [4:0] c_pass = 5'b11000;
  localparam logic [4:0] c_frz  = 5'b00001;
  localparam logic [4:0] c_flu  = 5'b11110;
  localparam logic [4:0] c_stl  = 5'b00010;
  localparam logic [4:0] c_zero = 5'b00000;

  logic                clk;
  logic                reset;
  logic                hazard_detected;
  logic                branch_taken;
  logic                dmem_busy;
  logic                clear_counters;
  logic                PCWrite;
  logic                IF_ID_Write;
  logic                IF_ID_Flush;
  logic                ID_EX_Bubble;
  logic                EX_MEM_Hold;
  logic [1:0]          state;
  logic [TB_CNT_W-1:0] stall_count;
  logic [TB_CNT_W-1:0] flush_count;
  logic                protocol_err;
  logic                timeout_err;

  pipeline_ctrl #(
    .MEM_TIMEOUT (TB_MEM_TIMEOUT),
    .CNT_W       (TB_CNT_W)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .hazard_detected (hazard_detected),
    .branch_taken    (branch_taken),
    .dmem_busy       (dmem_busy),
    .clear_counters  (clear_counters),
    .PCWrite         (PCWrite),
    .IF_ID_Write     (IF_ID_Write),
    .IF_ID_Flush     (IF_ID_Flush),
    .ID_EX_Bubble    (ID_EX_Bubble),
    .EX_MEM_Hold     (EX_MEM_Hold),
    .state           (state),
    .stall_count     (stall_count),
    .flush_count     (flush_count),
    .protocol_err    (protocol_err),
    .timeout_err     (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic [4:0] ctrl;
    logic [1:0] st;
    logic [1:0] sc;
    logic [1:0] fc;
    logic       pe;
    logic       te;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Apply one cycle of inputs and queue the outputs expected during it.
  task automatic step(input string nm, input logic b, input logic br,
                      input logic hz, input logic clr,
                      input logic [4:0] ec, input logic [1:0] es,
                      input logic [1:0] esc, input logic [1:0] efc,
                      input logic ep, input logic et);
    exp_t e;
    dmem_busy       = b;
    branch_taken    = br;
    hazard_detected = hz;
    clear_counters  = clr;
    e.nm = nm; e.ctrl = ec; e.st = es; e.sc = esc; e.fc = efc; e.pe = ep; e.te = et;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: outputs are settled mid-cycle, well away from the active edge.
  always @(negedge clk) begin
    exp_t        e;
    logic [12:0] got;
    logic [12:0] want;
    if (sb.size() != 0) begin
      e    = sb.pop_front();
      got  = {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Bubble, EX_MEM_Hold,
              state, stall_count, flush_count, protocol_err, timeout_err};
      want = {e.ctrl, e.st, e.sc, e.fc, e.pe, e.te};
      n_checks++;
      if (got === want) begin
        n_pass++;
      end else begin
        $display("FAIL %s: got ctrl=%b st=%0d sc=%0d fc=%0d pe=%b te=%b, expected ctrl=%b st=%0d sc=%0d fc=%0d pe=%b te=%b",
                 e.nm, got[12:8], got[7:6], got[5:4], got[3:2], got[1], got[0],
                 e.ctrl, e.st, e.sc, e.fc, e.pe, e.te);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected normal completion");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; dmem_busy = 1'b0; branch_taken = 1'b0;
    hazard_detected = 1'b0; clear_counters = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    // Strobes low under reset even with events asserted.
    step("rst_hold",   1,1,1,0, c_zero,0,0,0,0,0);
    reset = 1'b0;
    step("idle",       0,0,0,0, c_pass,0,0,0,0,0);
    // Load-use hazard
    step("lu_hz",      0,0,1,0, c_stl, 0,0,0,0,0);
    step("lu_ls",      0,0,0,0, c_pass,2,1,0,0,0);
    step("lu_run",     0,0,0,0, c_pass,0,1,0,0,0);
    step("clr0",       0,0,0,1, c_pass,0,1,0,0,0);
    // Branch beats hazard
    step("br_hz",      0,1,1,0, c_flu, 0,0,0,0,0);
    step("br_after",   0,0,0,0, c_pass,0,0,1,0,0);
    // Clear beats a same-cycle increment
    step("clr_vs_inc", 0,0,1,1, c_stl, 0,0,1,0,0);
    step("clr_after",  0,0,0,0, c_pass,2,0,0,0,0);
    // Memory wait, 3 busy cycles
    step("mw1",        1,0,0,0, c_frz, 0,0,0,0,0);
    step("mw2",        1,0,0,0, c_frz, 1,1,0,0,0);
    step("mw3",        1,0,0,0, c_frz, 1,2,0,0,0);
    step("mw_rel",     0,0,0,0, c_pass,1,3,0,0,0);
    step("mw_run",     0,0,0,0, c_pass,0,3,0,0,0);
    // Two more stalls: stall_count saturates at 3 after 5 stalls
    step("sat_hz1",    0,0,1,0, c_stl, 0,3,0,0,0);
    step("sat_ls1",    0,0,0,0, c_pass,2,3,0,0,0);
    step("sat_hz2",    0,0,1,0, c_stl, 0,3,0,0,0);
    step("sat_ls2",    0,0,0,0, c_pass,2,3,0,0,0);
    step("sat_run",    0,0,0,0, c_pass,0,3,0,0,0);
    step("clr1",       0,0,0,1, c_pass,0,3,0,0,0);
    // Branch inside LOAD_STALL
    step("ls_hz",      0,0,1,0, c_stl, 0,0,0,0,0);
    step("ls_br",      0,1,0,0, c_flu, 2,1,0,0,0);
    step("ls_br_run",  0,0,0,0, c_pass,0,1,1,0,0);
    // Memory busy inside LOAD_STALL goes to MEM_WAIT
    step("ls2_hz",     0,0,1,0, c_stl, 0,1,1,0,0);
    step("ls_busy",    1,0,0,0, c_frz, 2,2,1,0,0);
    step("ls_busy_mw", 0,0,0,0, c_pass,1,3,1,0,0);
    step("ls_busy_run",0,0,0,0, c_pass,0,3,1,0,0);
    step("clr2",       0,0,0,1, c_pass,0,3,1,0,0);
    // MEM_WAIT release with hazard, then with branch
    step("mwh_busy",   1,0,0,0, c_frz, 0,0,0,0,0);
    step("mw_hz",      0,0,1,0, c_stl, 1,1,0,0,0);
    step("mw_hz_ls",   0,0,0,0, c_pass,2,2,0,0,0);
    step("mw_hz_run",  0,0,0,0, c_pass,0,2,0,0,0);
    step("mwb_busy",   1,0,0,0, c_frz, 0,2,0,0,0);
    step("mw_br",      0,1,0,0, c_flu, 1,3,0,0,0);
    step("mw_br_run",  0,0,0,0, c_pass,0,3,1,0,0);
    step("clr3",       0,0,0,1, c_pass,0,3,1,0,0);
    // Timeout: busy for 6 cycles, flag visible after 4 MEM_WAIT cycles
    step("to1",        1,0,0,0, c_frz, 0,0,0,0,0);
    step("to2",        1,0,0,0, c_frz, 1,1,0,0,0);
    step("to3",        1,0,0,0, c_frz, 1,2,0,0,0);
    step("to4",        1,0,0,0, c_frz, 1,3,0,0,0);
    step("to5",        1,0,0,0, c_frz, 1,3,0,0,0);
    step("to6",        1,0,0,0, c_frz, 1,3,0,0,1);
    step("to_rel",     0,0,0,0, c_pass,1,3,0,0,1);
    step("to_run",     0,0,0,0, c_pass,0,3,0,0,1);
    step("clr4",       0,0,0,1, c_pass,0,3,0,0,1);
    // Protocol error: hazard held two cycles
    step("pe_hz1",     0,0,1,0, c_stl, 0,0,0,0,1);
    step("pe_hz2",     0,0,1,0, c_pass,2,1,0,0,1);
    step("pe_set",     0,0,0,0, c_pass,0,1,0,1,1);
    step("pe_clr",     0,0,0,1, c_pass,0,1,0,1,1);
    step("pe_sticky",  0,0,0,0, c_pass,0,0,0,1,1);
    // Reset asserted in MEM_WAIT
    step("rmw1",       1,0,0,0, c_frz, 0,0,0,1,1);
    step("rmw2",       1,0,0,0, c_frz, 1,1,0,1,1);
    reset = 1'b1;
    step("rst_in_mw",  1,0,0,0, c_zero,0,0,0,0,0);
    reset = 1'b0;
    step("post_rst_hz",0,0,1,0, c_stl, 0,0,0,0,0);
    step("post_rst_ls",0,0,0,0, c_pass,2,1,0,0,0);
    step("final",      0,0,0,0, c_pass,0,1,0,0,0);

    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (sb.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL drain: got %0d entries left, expected 0", sb.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_pipeline_ctrl
`default_nettype wire
